// File: rtl/layer1_pkg.sv
// rtl/layer1_pkg.sv - shared constants and state type for the layer-1 column drain
package layer1_pkg;

   localparam int NUM_LANES = 10;
   localparam int WORD_W    = 16;
   localparam int COL_W     = 160;

   typedef enum logic [1:0] {
      S_IDLE,
      S_ISSUE,
      S_SETTLE,
      S_DRAIN
   } l1_drain_state_t;

endpackage

// File: rtl/lane_relu.sv
// rtl/lane_relu.sv - 16-bit signed clamp to zero, bypassed when RELU is 0
module lane_relu
   import layer1_pkg::*;
#(
   parameter logic RELU = 1'b1
) (
   input  logic [WORD_W-1:0] word,
   output logic [WORD_W-1:0] clamped
);

   assign clamped = (RELU && word[WORD_W-1]) ? '0 : word;

endmodule

// File: rtl/layer1_col_drain.sv
// rtl/layer1_col_drain.sv - tap sequencer, accumulator clear timing and lane drain for the layer-1 MAC column
module layer1_col_drain
   import layer1_pkg::*;
#(
   parameter int   LAT   = 1,
   parameter int   TAP_W = 8,
   parameter logic RELU  = 1'b1
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               start,
   input  logic [TAP_W-1:0]   num_taps,
   output logic               tap_req,
   output logic [TAP_W-1:0]   tap_idx,
   output logic               mac_clear,
   input  logic [COL_W-1:0]   column,
   output logic [WORD_W-1:0]  out_data,
   output logic [3:0]         out_lane,
   output logic               out_valid,
   input  logic               out_ready,
   output logic               out_last,
   output logic               busy,
   output logic               done
);

   localparam logic [3:0] LAST_LANE = 4'(NUM_LANES - 1);

   l1_drain_state_t   state;
   logic [TAP_W-1:0]  n_taps;
   logic [TAP_W-1:0]  settle_cnt;
   logic [LAT-1:0]    clr_line;
   logic [WORD_W-1:0] shadow [NUM_LANES];
   logic [3:0]        next_lane;
   logic              first_tap;
   logic [WORD_W-1:0] sel_word;
   logic [WORD_W-1:0] relu_word;

   // Tap 0 is the only ISSUE cycle with index 0; its product lands LAT cycles later.
   assign first_tap = (state == S_ISSUE) && (tap_idx == '0);
   assign mac_clear = clr_line[LAT-1];
   assign next_lane = out_lane + 4'd1;

   // Entering DRAIN, lane 0 comes straight from the column being captured.
   always_comb begin
      sel_word = shadow[next_lane];
      if (state == S_SETTLE)
         sel_word = column[WORD_W-1:0];
   end

   lane_relu #(.RELU(RELU)) u_relu (
      .word    (sel_word),
      .clamped (relu_word)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= S_IDLE;
         n_taps     <= '0;
         settle_cnt <= '0;
         clr_line   <= '0;
         tap_req    <= 1'b0;
         tap_idx    <= '0;
         out_data   <= '0;
         out_lane   <= '0;
         out_valid  <= 1'b0;
         out_last   <= 1'b0;
         busy       <= 1'b0;
         done       <= 1'b0;
         for (int i = 0; i < NUM_LANES; i++)
            shadow[i] <= '0;
      end else begin
         done        <= 1'b0;
         clr_line[0] <= first_tap;
         for (int i = 1; i < LAT; i++)
            clr_line[i] <= clr_line[i-1];

         case (state)
            S_IDLE: begin
               if (start && (num_taps != '0)) begin
                  n_taps     <= num_taps;
                  tap_idx    <= '0;
                  settle_cnt <= '0;
                  tap_req    <= 1'b1;
                  busy       <= 1'b1;
                  state      <= S_ISSUE;
               end
            end
            S_ISSUE: begin
               if (tap_idx == n_taps - TAP_W'(1)) begin
                  tap_req    <= 1'b0;
                  tap_idx    <= '0;
                  settle_cnt <= '0;
                  state      <= S_SETTLE;
               end else begin
                  tap_idx <= tap_idx + TAP_W'(1);
               end
            end
            S_SETTLE: begin
               if (settle_cnt == TAP_W'(LAT)) begin
                  for (int i = 0; i < NUM_LANES; i++)
                     shadow[i] <= column[WORD_W*i +: WORD_W];
                  out_data  <= relu_word;
                  out_lane  <= '0;
                  out_valid <= 1'b1;
                  out_last  <= 1'b0;
                  state     <= S_DRAIN;
               end else begin
                  settle_cnt <= settle_cnt + TAP_W'(1);
               end
            end
            S_DRAIN: begin
               if (out_ready) begin
                  if (out_lane == LAST_LANE) begin
                     out_valid <= 1'b0;
                     out_last  <= 1'b0;
                     out_lane  <= '0;
                     out_data  <= '0;
                     busy      <= 1'b0;
                     done      <= 1'b1;
                     state     <= S_IDLE;
                  end else begin
                     out_lane <= next_lane;
                     out_data <= relu_word;
                     out_last <= (next_lane == LAST_LANE);
                  end
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_layer1_col_drain.sv
// tb/tb_layer1_col_drain.sv - directed bench for layer1_col_drain with a behavioural MAC column
module tb_layer1_col_drain;
   import layer1_pkg::*;

   localparam int LAT   = 1;
   localparam int TAP_W = 8;

   logic              clk = 1'b0;
   logic              reset;
   logic              start;
   logic [TAP_W-1:0]  num_taps;
   logic              out_ready;
   logic [COL_W-1:0]  column;

   logic              tap_req, mac_clear, out_valid, out_last, busy, done;
   logic [TAP_W-1:0]  tap_idx;
   logic [WORD_W-1:0] out_data;
   logic [3:0]        out_lane;

   logic              nr_tap_req, nr_mac_clear, nr_out_valid, nr_out_last, nr_busy, nr_done;
   logic [TAP_W-1:0]  nr_tap_idx;
   logic [WORD_W-1:0] nr_out_data;
   logic [3:0]        nr_out_lane;

   int n_checks = 0;
   int n_fail   = 0;

   logic [WORD_W-1:0] pix     [NUM_LANES];
   logic [WORD_W-1:0] acc     [NUM_LANES];
   logic [WORD_W-1:0] exp_raw [NUM_LANES];
   logic [WORD_W-1:0] exp_rel [NUM_LANES];
   logic              req_d;

   always #5 clk = ~clk;

   layer1_col_drain #(.LAT(LAT), .TAP_W(TAP_W), .RELU(1'b1)) dut (
      .clk(clk), .reset(reset), .start(start), .num_taps(num_taps),
      .tap_req(tap_req), .tap_idx(tap_idx), .mac_clear(mac_clear), .column(column),
      .out_data(out_data), .out_lane(out_lane), .out_valid(out_valid), .out_ready(out_ready),
      .out_last(out_last), .busy(busy), .done(done)
   );

   layer1_col_drain #(.LAT(LAT), .TAP_W(TAP_W), .RELU(1'b0)) dut_nr (
      .clk(clk), .reset(reset), .start(start), .num_taps(num_taps),
      .tap_req(nr_tap_req), .tap_idx(nr_tap_idx), .mac_clear(nr_mac_clear), .column(column),
      .out_data(nr_out_data), .out_lane(nr_out_lane), .out_valid(nr_out_valid), .out_ready(out_ready),
      .out_last(nr_out_last), .busy(nr_busy), .done(nr_done)
   );

   // MAC column model: weight 1, pixels one cycle after the request; junk keeps accumulating otherwise.
   always @(posedge clk) begin
      req_d <= tap_req;
      for (int i = 0; i < NUM_LANES; i++)
         acc[i] <= (mac_clear ? 16'h0000 : acc[i]) + (req_d ? pix[i] : 16'h0011);
   end

   always_comb begin
      column = '0;
      for (int i = 0; i < NUM_LANES; i++)
         column[WORD_W*i +: WORD_W] = acc[i];
   end

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic check_reset_vals(input string tag);
      check_eq({tag, "_tap_req"},   32'(tap_req),   0);
      check_eq({tag, "_tap_idx"},   32'(tap_idx),   0);
      check_eq({tag, "_mac_clear"}, 32'(mac_clear), 0);
      check_eq({tag, "_out_valid"}, 32'(out_valid), 0);
      check_eq({tag, "_out_last"},  32'(out_last),  0);
      check_eq({tag, "_out_data"},  32'(out_data),  0);
      check_eq({tag, "_out_lane"},  32'(out_lane),  0);
      check_eq({tag, "_busy"},      32'(busy),      0);
      check_eq({tag, "_done"},      32'(done),      0);
   endtask

   task automatic set_expect(input int n);
      for (int i = 0; i < NUM_LANES; i++) begin
         exp_raw[i] = 16'(n * int'(pix[i]));
         exp_rel[i] = exp_raw[i][15] ? 16'h0000 : exp_raw[i];
      end
   endtask

   // Returns at the negedge of ISSUE cycle 0.
   task automatic do_start(input logic [TAP_W-1:0] n);
      @(negedge clk);
      start    = 1'b1;
      num_taps = n;
      @(negedge clk);
      start    = 1'b0;
   endtask

   task automatic issue_phase(input int n, input bit poke);
      int taps = 0, clr_cnt = 0, clr_cyc = -1, first_valid = -1;
      check_eq("busy_rise", 32'(busy), 1);
      for (int k = 0; k < 40; k++) begin
         if (tap_req) begin
            check_eq("tap_idx", 32'(tap_idx), 32'(taps));
            taps++;
         end
         if (mac_clear) begin
            clr_cnt++;
            clr_cyc = k;
         end
         if (out_valid) begin
            first_valid = k;
            break;
         end
         start    = poke && (k == 1);
         num_taps = 8'd5;
         @(negedge clk);
      end
      start = 1'b0;
      check_eq("tap_count",   32'(taps),        32'(n));
      check_eq("clear_count", 32'(clr_cnt),     1);
      check_eq("clear_cycle", 32'(clr_cyc),     32'(LAT));
      check_eq("first_valid", 32'(first_valid), 32'(n + LAT + 1));
   endtask

   task automatic drain_phase(input int stall_lane, input bit poke);
      int  lane_exp = 0;
      int  stalls   = 0;
      bit  rdy;
      for (int cyc = 0; cyc < 60 && lane_exp < NUM_LANES; cyc++) begin
         if (!out_valid) begin
            check_eq("drain_valid", 32'(out_valid), 1);
            break;
         end
         rdy = !(lane_exp == stall_lane && stalls < 2);
         if (!rdy) stalls++;
         out_ready = rdy;
         start     = poke && (lane_exp == 5);
         num_taps  = 8'd4;
         check_eq("lane",      32'(out_lane),    32'(lane_exp));
         check_eq("data_relu", 32'(out_data),    32'(exp_rel[lane_exp]));
         check_eq("data_raw",  32'(nr_out_data), 32'(exp_raw[lane_exp]));
         check_eq("last",      32'(out_last),    32'(lane_exp == NUM_LANES - 1));
         check_eq("done_early", 32'(done),       0);
         @(negedge clk);
         if (rdy) lane_exp++;
      end
      start     = 1'b0;
      out_ready = 1'b0;
      check_eq("lanes_drained", 32'(lane_exp),  32'(NUM_LANES));
      check_eq("done_pulse",    32'(done),      1);
      check_eq("busy_fall",     32'(busy),      0);
      check_eq("valid_fall",    32'(out_valid), 0);
      @(negedge clk);
      check_eq("done_once",     32'(done),      0);
      check_eq("idle_busy",     32'(busy),      0);
      check_eq("idle_tap_req",  32'(tap_req),   0);
   endtask

   initial begin
      reset     = 1'b1;
      start     = 1'b0;
      num_taps  = '0;
      out_ready = 1'b0;
      for (int i = 0; i < NUM_LANES; i++) begin
         pix[i] = '0;
         acc[i] = '0;
      end
      req_d = 1'b0;
      repeat (2) @(negedge clk);
      check_reset_vals("por");
      reset = 1'b0;

      // N=0 start is ignored
      @(negedge clk);
      start = 1'b1;
      num_taps = 8'd0;
      @(negedge clk);
      start = 1'b0;
      check_eq("n0_busy", 32'(busy), 0);
      check_eq("n0_tap_req", 32'(tap_req), 0);
      @(negedge clk);
      check_eq("n0_busy2", 32'(busy), 0);

      // N=3, lanes 3..30, stall on lane 4, stray starts in ISSUE and DRAIN
      for (int i = 0; i < NUM_LANES; i++) pix[i] = 16'(i + 1);
      set_expect(3);
      do_start(8'd3);
      issue_phase(3, 1'b1);
      drain_phase(4, 1'b1);

      // N=2 with lane 2 reaching 0xFFF0: clamped by ReLU, raw otherwise
      for (int i = 0; i < NUM_LANES; i++) pix[i] = 16'(i + 5);
      pix[2] = 16'hFFF8;
      set_expect(2);
      do_start(8'd2);
      issue_phase(2, 1'b0);
      drain_phase(-1, 1'b0);

      // N=1: clear falls in SETTLE
      for (int i = 0; i < NUM_LANES; i++) pix[i] = 16'(10 * i + 7);
      set_expect(1);
      do_start(8'd1);
      issue_phase(1, 1'b0);
      drain_phase(-1, 1'b0);

      // reset mid-ISSUE
      do_start(8'd3);
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      check_reset_vals("rst_issue");

      // reset mid-DRAIN
      do_start(8'd5);
      out_ready = 1'b1;
      for (int k = 0; k < 40 && !(out_valid && out_lane == 4'd2); k++) @(negedge clk);
      check_eq("rst_reach_lane2", 32'(out_lane), 2);
      reset     = 1'b1;
      out_ready = 1'b0;
      @(negedge clk);
      reset = 1'b0;
      check_reset_vals("rst_drain");
      @(negedge clk);
      check_eq("rst_no_done", 32'(done), 0);

      // clean run after resets
      for (int i = 0; i < NUM_LANES; i++) pix[i] = 16'(100 + 3 * i);
      set_expect(2);
      do_start(8'd2);
      issue_phase(2, 1'b0);
      drain_phase(7, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: got no finish expected finish");
      $fatal(1);
   end

endmodule
